// File: rtl/timer0_periph.sv
// timer0_periph - 8-bit Timer/Counter0 with prescaler, compare unit A and
// overflow/compare interrupt flags, as a responder on the native memory bus.
//
// Ports
//   clk, rst      system clock; asynchronous active-high reset
//   mem_valid     bus request (already decoded for this block)
//   mem_addr      byte address, [4:2] selects the register
//   mem_wdata     write data, [7:0] used
//   mem_wstrb     0 = read, [0] = write low byte, other non-zero = ack only
//   mem_rdata     registered read data, upper 24 bits zero
//   mem_ready     one-cycle completion pulse, one cycle after acceptance
//   oc0a          compare output A pin
//   irq           level interrupt, |(TIFR0 & TIMSK0)
module timer0_periph (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        oc0a,
    output logic        irq
);
    localparam logic [2:0] A_TCCR0A = 3'd0;
    localparam logic [2:0] A_TCCR0B = 3'd1;
    localparam logic [2:0] A_TCNT0  = 3'd2;
    localparam logic [2:0] A_OCR0A  = 3'd3;
    localparam logic [2:0] A_TIMSK0 = 3'd4;
    localparam logic [2:0] A_TIFR0  = 3'd5;

    logic [1:0] r_com;
    logic       r_wgm;
    logic [2:0] r_cs;
    logic [7:0] r_tcnt;
    logic [7:0] r_ocr;
    logic [1:0] r_timsk;
    logic       r_tov;
    logic       r_ocfa;
    logic       r_oc0a;
    logic       r_block;
    logic       r_ready;
    logic [7:0] r_rdata;
    logic [9:0] r_presc;

    logic [2:0] w_sel;
    logic [7:0] w_wd;
    logic       w_acc, w_wr, w_rd;
    logic       w_run, w_tick, w_cs_chg;
    logic [9:0] w_top;
    logic       w_tcnt_wr, w_match, w_force, w_tov_set;
    logic       w_tov_clr, w_ocf_clr;
    logic [7:0] w_tcnt_next;
    logic       w_oc_next;
    logic [7:0] w_rmux;
    logic       w_unused;

    assign w_sel  = mem_addr[4:2];
    assign w_wd   = mem_wdata[7:0];
    // Only accept while no completion is pending, so one request = one ack.
    assign w_acc  = mem_valid & ~r_ready;
    assign w_wr   = w_acc & mem_wstrb[0];
    assign w_rd   = w_acc & (mem_wstrb == 4'b0000);

    assign w_unused = ^{mem_addr[31:5], mem_addr[1:0], mem_wdata[31:8]};

    // Prescaler terminal count per clock select; 0, 6, 7 stop the timer.
    always_comb begin
        w_run = 1'b1;
        w_top = 10'd0;
        case (r_cs)
            3'd1:    w_top = 10'd0;
            3'd2:    w_top = 10'd7;
            3'd3:    w_top = 10'd63;
            3'd4:    w_top = 10'd255;
            3'd5:    w_top = 10'd1023;
            default: w_run = 1'b0;
        endcase
    end

    assign w_tick    = w_run & (r_presc == w_top);
    assign w_cs_chg  = w_wr & (w_sel == A_TCCR0B) & (w_wd[2:0] != r_cs);
    assign w_tcnt_wr = w_wr & (w_sel == A_TCNT0);
    // A bus load of TCNT0 wins over the tick: no increment, no compare.
    assign w_match   = w_tick & ~w_tcnt_wr & ~r_block & (r_tcnt == r_ocr);
    assign w_force   = w_wr & (w_sel == A_TCCR0B) & w_wd[7];
    // The next value after 0xFF is always 0x00 in both modes.
    assign w_tov_set = w_tick & ~w_tcnt_wr & (r_tcnt == 8'hFF);
    assign w_tov_clr = w_wr & (w_sel == A_TIFR0) & w_wd[0];
    assign w_ocf_clr = w_wr & (w_sel == A_TIFR0) & w_wd[1];
    assign w_tcnt_next = (r_wgm && (r_tcnt == r_ocr)) ? 8'h00 : r_tcnt + 8'd1;

    always_comb begin
        w_oc_next = r_oc0a;
        case (r_com)
            2'b01:   w_oc_next = ~r_oc0a;
            2'b10:   w_oc_next = 1'b0;
            2'b11:   w_oc_next = 1'b1;
            default: w_oc_next = r_oc0a;
        endcase
    end

    always_comb begin
        w_rmux = 8'h00;
        case (w_sel)
            A_TCCR0A: w_rmux = {r_com, 5'b00000, r_wgm};
            A_TCCR0B: w_rmux = {5'b00000, r_cs};
            A_TCNT0:  w_rmux = r_tcnt;
            A_OCR0A:  w_rmux = r_ocr;
            A_TIMSK0: w_rmux = {6'b000000, r_timsk};
            A_TIFR0:  w_rmux = {6'b000000, r_ocfa, r_tov};
            default:  w_rmux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_com   <= 2'b00;
            r_wgm   <= 1'b0;
            r_cs    <= 3'd0;
            r_tcnt  <= 8'h00;
            r_ocr   <= 8'h00;
            r_timsk <= 2'b00;
            r_tov   <= 1'b0;
            r_ocfa  <= 1'b0;
            r_oc0a  <= 1'b0;
            r_block <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 8'h00;
            r_presc <= 10'd0;
        end else begin
            r_ready <= w_acc;
            if (w_rd) r_rdata <= w_rmux;

            if (!w_run || w_cs_chg || w_tick) r_presc <= 10'd0;
            else                              r_presc <= r_presc + 10'd1;

            if (w_tcnt_wr)   r_tcnt <= w_wd;
            else if (w_tick) r_tcnt <= w_tcnt_next;

            // Block survives until the first tick after the TCNT0 load.
            if (w_tcnt_wr)   r_block <= 1'b1;
            else if (w_tick) r_block <= 1'b0;

            if (w_match || w_force) r_oc0a <= w_oc_next;

            // Hardware set beats a same-edge write-1-to-clear.
            r_tov  <= w_tov_set | (r_tov & ~w_tov_clr);
            r_ocfa <= w_match   | (r_ocfa & ~w_ocf_clr);

            if (w_wr) begin
                case (w_sel)
                    A_TCCR0A: begin
                        r_com <= w_wd[7:6];
                        r_wgm <= w_wd[0];
                    end
                    A_TCCR0B: r_cs    <= w_wd[2:0];
                    A_OCR0A:  r_ocr   <= w_wd;
                    A_TIMSK0: r_timsk <= w_wd[1:0];
                    default:  ;
                endcase
            end
        end
    end

    assign mem_rdata = {24'h000000, r_rdata};
    assign mem_ready = r_ready;
    assign oc0a      = r_oc0a;
    assign irq       = |({r_ocfa, r_tov} & r_timsk);

endmodule

// File: tb/tb_timer0_periph.sv
// tb_timer0_periph - directed test-plan scenarios plus randomized bus traffic,
// checked every cycle against a behavioural Timer0 model kept in the bench.
module tb_timer0_periph;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        oc0a;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer0_periph dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .oc0a(oc0a), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int dv[8] = '{0, 1, 8, 64, 256, 1024, 0, 0};
    int m_com = 0, m_cs = 0, m_cnt = 0, m_ocr = 0, m_mask = 0, m_pre = 0, m_rd = 0;
    bit m_wgm = 0, m_tov = 0, m_ocf = 0, m_pin = 0, m_blk = 0, m_rdy = 0;

    function automatic bit act(input int com, input bit p);
        case (com)
            1:       return !p;
            2:       return 1'b0;
            3:       return 1'b1;
            default: return p;
        endcase
    endfunction

    function automatic int mreg(input int a);
        case (a)
            0:       return m_com * 64 + int'(m_wgm);
            1:       return m_cs;
            2:       return m_cnt;
            3:       return m_ocr;
            4:       return m_mask;
            5:       return int'(m_ocf) * 2 + int'(m_tov);
            default: return 0;
        endcase
    endfunction

    function automatic bit m_irq();
        return (m_tov && (m_mask % 2 == 1)) || (m_ocf && (m_mask / 2 == 1));
    endfunction

    always @(posedge clk or posedge rst) begin : model_b
        int a, wd, div;
        bit acc, wr, tick, tcw, hit, frc, tovs, tifr;
        if (rst) begin
            m_com <= 0; m_cs <= 0; m_cnt <= 0; m_ocr <= 0; m_mask <= 0;
            m_pre <= 0; m_rd <= 0; m_wgm <= 0; m_tov <= 0; m_ocf <= 0;
            m_pin <= 0; m_blk <= 0; m_rdy <= 0;
        end else begin
            a    = int'(mem_addr[4:2]);
            wd   = int'(mem_wdata[7:0]);
            acc  = mem_valid && !m_rdy;
            wr   = acc && mem_wstrb[0];
            div  = dv[m_cs];
            tick = (div != 0) && (m_pre == div - 1);
            tcw  = wr && a == 2;
            hit  = tick && !tcw && !m_blk && m_cnt == m_ocr;
            frc  = wr && a == 1 && wd >= 128;
            tovs = tick && !tcw && m_cnt == 255;
            tifr = wr && a == 5;
            m_rdy <= acc;
            if (acc && mem_wstrb == 4'b0000) m_rd <= mreg(a);
            if (div == 0 || (wr && a == 1 && wd % 8 != m_cs)) m_pre <= 0;
            else m_pre <= (m_pre + 1) % div;
            if (tcw) m_cnt <= wd;
            else if (tick) m_cnt <= (m_wgm && m_cnt == m_ocr) ? 0 : (m_cnt + 1) % 256;
            if (tcw) m_blk <= 1;
            else if (tick) m_blk <= 0;
            if (hit || frc) m_pin <= act(m_com, m_pin);
            m_tov <= tovs || (m_tov && !(tifr && wd % 2 == 1));
            m_ocf <= hit || (m_ocf && !(tifr && (wd / 2) % 2 == 1));
            if (wr && a == 0) begin m_com <= wd / 64; m_wgm <= bit'(wd % 2); end
            if (wr && a == 1) m_cs <= wd % 8;
            if (wr && a == 3) m_ocr <= wd;
            if (wr && a == 4) m_mask <= wd % 4;
        end
    end

    // Every cycle the pins and bus outputs must agree with the model.
    always @(negedge clk) begin
        chk("oc0a", {31'b0, oc0a}, {31'b0, m_pin});
        chk("irq", {31'b0, irq}, {31'b0, m_irq()});
        chk("ready", {31'b0, mem_ready}, {31'b0, m_rdy});
        chk("rdata", mem_rdata, m_rd);
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic [4:0] off, input logic [7:0] d,
                       input logic [3:0] s, output logic [31:0] v);
        logic [31:0] adr;
        @(negedge clk);
        adr = $urandom;
        adr[4:0] = off;
        mem_valid = 1'b1;
        mem_addr  = adr;
        mem_wdata = {$urandom_range(0, 32'hFFFFFF), d};
        mem_wstrb = s;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("ack", {31'b0, mem_ready}, 32'd1);
        v = mem_rdata;
    endtask

    task automatic wr(input logic [4:0] off, input logic [7:0] d);
        logic [31:0] v;
        bus(off, d, {3'($urandom_range(0, 7)), 1'b1}, v);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] v);
        bus(off, 8'($urandom), 4'b0000, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_oc0a", {31'b0, oc0a}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int t0, t1;
        bit prev;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of every offset.
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), v);
            chk("reset_reg", v, 32'd0);
        end

        // Overflow interrupt.
        wr(5'h10, 8'h01);
        wr(5'h08, 8'hFE);
        wr(5'h04, 8'h01);
        rd(5'h08, v);
        chk("ovf_tcnt_ff", v, 32'h0000_00FF);
        chk("ovf_irq_hi", {31'b0, irq}, 32'd1);
        wr(5'h14, 8'h01);
        chk("ovf_irq_clr", {31'b0, irq}, 32'd0);

        // Bus corner cases.
        do_reset();
        rd(5'h18, v);
        chk("rd_18", v, 32'd0);
        wr(5'h1C, 8'hFF);
        rd(5'h1C, v);
        chk("rd_1c", v, 32'd0);
        wr(5'h0C, 8'h5A);
        bus(5'h0C, 8'hA5, 4'b0000, v);
        chk("wstrb0", v, 32'h5A);
        rd(5'h0C, v);
        chk("ocr_keep", v, 32'h5A);
        wr(5'h00, 8'hC0);
        wr(5'h04, 8'h80);
        chk("foc_pin", {31'b0, oc0a}, 32'd1);
        rd(5'h14, v);
        chk("foc_tifr", v, 32'd0);
        rd(5'h04, v);
        chk("foc_tccr0b", v, 32'd0);

        // CTC toggle: one oc0a edge every 4 ticks of /8 = 32 clk.
        do_reset();
        wr(5'h0C, 8'h03);
        wr(5'h00, 8'h41);
        wr(5'h04, 8'h02);
        t0 = -1; t1 = -1;
        prev = oc0a;
        for (int i = 0; i < 200 && t0 < 0; i++) begin
            @(negedge clk);
            if (oc0a != prev) t0 = cyc;
        end
        prev = oc0a;
        for (int i = 0; i < 200 && t0 >= 0 && t1 < 0; i++) begin
            @(negedge clk);
            if (oc0a != prev) t1 = cyc;
        end
        chk("ctc_seen", {31'b0, t0 >= 0 && t1 >= 0}, 32'd1);
        if (t0 >= 0 && t1 >= 0) chk("ctc_half_period", t1 - t0, 32'd32);

        // Compare blocking after a TCNT0 write.
        do_reset();
        wr(5'h0C, 8'h05);
        wr(5'h04, 8'h01);
        repeat (10) @(negedge clk);
        wr(5'h14, 8'h02);
        wr(5'h08, 8'h05);
        rd(5'h08, v);
        chk("blk_tcnt", v, 32'h06);
        rd(5'h14, v);
        chk("blk_ocfa", v & 32'h2, 32'h0);
        repeat (260) @(negedge clk);
        rd(5'h14, v);
        chk("blk_next_match", v & 32'h2, 32'h2);

        // W1C lands on the match edge: the set wins.
        do_reset();
        wr(5'h10, 8'h02);
        wr(5'h0C, 8'h20);
        wr(5'h04, 8'h01);
        wr(5'h08, 8'h10);
        repeat (15) @(negedge clk);
        wr(5'h14, 8'h02);
        rd(5'h14, v);
        chk("w1c_vs_set", v & 32'h2, 32'h2);

        // Reset in the middle of counting with pin and irq high.
        do_reset();
        wr(5'h00, 8'hC0);
        wr(5'h0C, 8'h42);
        wr(5'h10, 8'h02);
        wr(5'h08, 8'h40);
        wr(5'h04, 8'h01);
        repeat (4) @(negedge clk);
        chk("mid_pin", {31'b0, oc0a}, 32'd1);
        chk("mid_irq", {31'b0, irq}, 32'd1);
        rd(5'h08, v);
        do_reset();
        repeat (3) @(negedge clk);
        rd(5'h08, v);
        chk("post_rst_tcnt", v, 32'd0);
        repeat (5) @(negedge clk);
        rd(5'h08, v);
        chk("post_rst_still", v, 32'd0);

        // Randomized traffic, model checks every cycle.
        for (int t = 0; t < 600; t++) begin
            logic [4:0] off;
            logic [7:0] d;
            int k;
            off = 5'($urandom_range(0, 7) * 4);
            d = 8'($urandom);
            if (off == 5'h04 && $urandom_range(0, 3) != 0) d[2:0] = 3'($urandom_range(1, 3));
            k = $urandom_range(0, 9);
            if (k < 4)      bus(off, d, 4'b0000, v);
            else if (k < 9) bus(off, d, {3'($urandom_range(0, 7)), 1'b1}, v);
            else            bus(off, d, {3'($urandom_range(1, 7)), 1'b0}, v);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
